// File: rtl/id_control_unit.sv
// ID-stage main control decoder and ID/EX control register with HALT drain sequencing.
// Optional feature: define ILLEGAL_TRAP_EN to enable the sticky illegal-opcode flag.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_RUN    | normal decode and issue
//  ST_DRAIN  | HALT accepted, issuing bubbles while the pipe empties
//  ST_HALTED | pipeline drained, bubbles only until reset
module id_control_unit #(
    parameter int NB_INSTR     = 32,
    parameter int NB_ALU_OP    = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NB_INSTR-1:0]  i_instr,
    input  logic                 i_instr_valid,
    input  logic                 i_enable,
    input  logic                 i_stall,
    input  logic                 i_flush,
    output logic [NB_ALU_OP-1:0] o_alu_op,
    output logic                 o_alu_src,
    output logic [1:0]           o_reg_dst,
    output logic                 o_reg_write,
    output logic                 o_mem_read,
    output logic                 o_mem_write,
    output logic                 o_mem_to_reg,
    output logic [1:0]           o_mem_width,
    output logic                 o_mem_unsigned,
    output logic                 o_branch_eq,
    output logic                 o_branch_ne,
    output logic                 o_jump,
    output logic                 o_jump_reg,
    output logic                 o_link,
    output logic                 o_valid,
    output logic                 o_halted,
    output logic                 o_illegal
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_LWU   = 6'b100111;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    localparam logic [NB_ALU_OP-1:0] ALU_ADD   = NB_ALU_OP'(4'b0000);
    localparam logic [NB_ALU_OP-1:0] ALU_ADDU  = NB_ALU_OP'(4'b0001);
    localparam logic [NB_ALU_OP-1:0] ALU_RTYPE = NB_ALU_OP'(4'b0010);
    localparam logic [NB_ALU_OP-1:0] ALU_AND   = NB_ALU_OP'(4'b0100);
    localparam logic [NB_ALU_OP-1:0] ALU_OR    = NB_ALU_OP'(4'b0101);
    localparam logic [NB_ALU_OP-1:0] ALU_BR    = NB_ALU_OP'(4'b0111);
    localparam logic [NB_ALU_OP-1:0] ALU_XOR   = NB_ALU_OP'(4'b1000);
    localparam logic [NB_ALU_OP-1:0] ALU_LUI   = NB_ALU_OP'(4'b1001);
    localparam logic [NB_ALU_OP-1:0] ALU_SLT   = NB_ALU_OP'(4'b1100);
    localparam logic [NB_ALU_OP-1:0] ALU_SLTU  = NB_ALU_OP'(4'b1101);

    localparam logic [1:0] DST_RT  = 2'b00;
    localparam logic [1:0] DST_RD  = 2'b01;
    localparam logic [1:0] DST_R31 = 2'b10;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    typedef struct packed {
        logic [NB_ALU_OP-1:0] alu_op;
        logic                 alu_src;
        logic [1:0]           reg_dst;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
        logic                 mem_to_reg;
        logic [1:0]           mem_width;
        logic                 mem_unsigned;
        logic                 branch_eq;
        logic                 branch_ne;
        logic                 jump;
        logic                 jump_reg;
        logic                 link;
        logic                 valid;
    } ctrl_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    ctrl_t            ctrl_q;
    ctrl_t            ctrl_d;
    logic             halt_d;
    logic             illegal_d;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             accept;

    assign opcode = i_instr[NB_INSTR-1 -: 6];
    assign funct  = i_instr[5:0];
    assign accept = i_instr_valid && !i_flush && !i_stall;

    // Pure opcode decode; illegal opcodes and HALT both leave ctrl_d as a bubble.
    always_comb begin
        ctrl_d    = '0;
        halt_d    = 1'b0;
        illegal_d = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl_d.alu_op    = ALU_RTYPE;
                ctrl_d.reg_dst   = DST_RD;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.valid     = 1'b1;
                if (funct == FN_JR) begin
                    ctrl_d.jump_reg  = 1'b1;
                    ctrl_d.reg_write = 1'b0;
                end else if (funct == FN_JALR) begin
                    ctrl_d.jump_reg = 1'b1;
                    ctrl_d.link     = 1'b1;
                end
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
                ctrl_d.alu_op     = ALU_ADD;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.reg_dst    = DST_RT;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_read   = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.valid      = 1'b1;
                ctrl_d.mem_unsigned = (opcode == OP_LBU) || (opcode == OP_LHU) || (opcode == OP_LWU);
                if ((opcode == OP_LB) || (opcode == OP_LBU)) begin
                    ctrl_d.mem_width = W_BYTE;
                end else if ((opcode == OP_LH) || (opcode == OP_LHU)) begin
                    ctrl_d.mem_width = W_HALF;
                end else begin
                    ctrl_d.mem_width = W_WORD;
                end
            end
            OP_SB, OP_SH, OP_SW: begin
                ctrl_d.alu_op    = ALU_ADD;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.mem_write = 1'b1;
                ctrl_d.valid     = 1'b1;
                if (opcode == OP_SB) begin
                    ctrl_d.mem_width = W_BYTE;
                end else if (opcode == OP_SH) begin
                    ctrl_d.mem_width = W_HALF;
                end else begin
                    ctrl_d.mem_width = W_WORD;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_dst   = DST_RT;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.valid     = 1'b1;
                case (opcode)
                    OP_ADDIU: ctrl_d.alu_op = ALU_ADDU;
                    OP_SLTI:  ctrl_d.alu_op = ALU_SLT;
                    OP_SLTIU: ctrl_d.alu_op = ALU_SLTU;
                    OP_ANDI:  ctrl_d.alu_op = ALU_AND;
                    OP_ORI:   ctrl_d.alu_op = ALU_OR;
                    OP_XORI:  ctrl_d.alu_op = ALU_XOR;
                    OP_LUI:   ctrl_d.alu_op = ALU_LUI;
                    default:  ctrl_d.alu_op = ALU_ADD;
                endcase
            end
            OP_BEQ: begin
                ctrl_d.alu_op    = ALU_BR;
                ctrl_d.branch_eq = 1'b1;
                ctrl_d.valid     = 1'b1;
            end
            OP_BNE: begin
                ctrl_d.alu_op    = ALU_BR;
                ctrl_d.branch_ne = 1'b1;
                ctrl_d.valid     = 1'b1;
            end
            OP_J: begin
                ctrl_d.jump  = 1'b1;
                ctrl_d.valid = 1'b1;
            end
            OP_JAL: begin
                ctrl_d.jump      = 1'b1;
                ctrl_d.link      = 1'b1;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = DST_R31;
                ctrl_d.valid     = 1'b1;
            end
            OP_HALT: halt_d = 1'b1;
            default: illegal_d = 1'b1;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            ctrl_q    <= '0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else if (i_enable) begin
            case (state_q)
                ST_RUN: begin
                    ctrl_q <= '0;
                    if (accept) begin
                        if (halt_d) begin
                            state_q <= ST_DRAIN;
                            cnt_q   <= CNT_W'(DRAIN_CYCLES - 1);
                        end else begin
                            ctrl_q <= ctrl_d;
                        end
`ifdef ILLEGAL_TRAP_EN
                        if (illegal_d) begin
                            illegal_q <= 1'b1;
                        end
`endif
                    end
                end
                ST_DRAIN: begin
                    ctrl_q <= '0;
                    if (cnt_q == '0) begin
                        state_q <= ST_HALTED;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_HALTED: ctrl_q <= '0;
                default: begin
                    ctrl_q  <= '0;
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign o_illegal = illegal_q;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_d;
    assign o_illegal      = 1'b0;
`endif

    // rs/rt/rd/shamt fields are consumed by other ID logic, not by the control decode.
    logic unused_instr;
    assign unused_instr = ^i_instr[NB_INSTR-7:6];

    assign o_alu_op       = ctrl_q.alu_op;
    assign o_alu_src      = ctrl_q.alu_src;
    assign o_reg_dst      = ctrl_q.reg_dst;
    assign o_reg_write    = ctrl_q.reg_write;
    assign o_mem_read     = ctrl_q.mem_read;
    assign o_mem_write    = ctrl_q.mem_write;
    assign o_mem_to_reg   = ctrl_q.mem_to_reg;
    assign o_mem_width    = ctrl_q.mem_width;
    assign o_mem_unsigned = ctrl_q.mem_unsigned;
    assign o_branch_eq    = ctrl_q.branch_eq;
    assign o_branch_ne    = ctrl_q.branch_ne;
    assign o_jump         = ctrl_q.jump;
    assign o_jump_reg     = ctrl_q.jump_reg;
    assign o_link         = ctrl_q.link;
    assign o_valid        = ctrl_q.valid;
    assign o_halted       = (state_q == ST_HALTED);

endmodule

// File: tb/tb_id_control_unit.sv
// Directed bench for id_control_unit: decode vectors, bubbles, enable hold, HALT drain, reset.
module tb_id_control_unit;

    logic        clk_sys;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        enable;
    logic        stall;
    logic        flush;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic [1:0]  reg_dst;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [1:0]  mem_width;
    logic        mem_unsigned;
    logic        branch_eq;
    logic        branch_ne;
    logic        jump;
    logic        jump_reg;
    logic        link;
    logic        valid;
    logic        halted;
    logic        illegal;

    int n_vec;
    int n_err;

    id_control_unit #(
        .NB_INSTR    (32),
        .NB_ALU_OP   (4),
        .DRAIN_CYCLES(3)
    ) dut (
        .i_clk         (clk_sys),
        .i_rst_n       (rst_n),
        .i_instr       (instr),
        .i_instr_valid (instr_valid),
        .i_enable      (enable),
        .i_stall       (stall),
        .i_flush       (flush),
        .o_alu_op      (alu_op),
        .o_alu_src     (alu_src),
        .o_reg_dst     (reg_dst),
        .o_reg_write   (reg_write),
        .o_mem_read    (mem_read),
        .o_mem_write   (mem_write),
        .o_mem_to_reg  (mem_to_reg),
        .o_mem_width   (mem_width),
        .o_mem_unsigned(mem_unsigned),
        .o_branch_eq   (branch_eq),
        .o_branch_ne   (branch_ne),
        .o_jump        (jump),
        .o_jump_reg    (jump_reg),
        .o_link        (link),
        .o_valid       (valid),
        .o_halted      (halted),
        .o_illegal     (illegal)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic [19:0] bundle;
    assign bundle = {alu_op, alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg,
                     mem_width, mem_unsigned, branch_eq, branch_ne, jump, jump_reg, link, valid};

    function automatic logic [19:0] mk(input logic [3:0] a, input logic src, input logic [1:0] dst,
                                       input logic rw, input logic mr, input logic mw, input logic m2r,
                                       input logic [1:0] wd, input logic uns, input logic beq,
                                       input logic bne, input logic j, input logic jr,
                                       input logic lnk, input logic v);
        return {a, src, dst, rw, mr, mw, m2r, wd, uns, beq, bne, j, jr, lnk, v};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic v, input logic en,
                        input logic st, input logic fl);
        instr       = ins;
        instr_valid = v;
        enable      = en;
        stall       = st;
        flush       = fl;
        @(posedge clk_sys);
        #1;
    endtask

    typedef struct {
        string       tag;
        logic [31:0] ins;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[$];
    logic exp_ill;

    localparam logic [19:0] BUB  = 20'h0;
    localparam logic [31:0] HALT = 32'hFC00_0000;
    localparam logic [31:0] SW   = 32'hAC22_0000;

    initial begin
        n_vec = 0;
        n_err = 0;
`ifdef ILLEGAL_TRAP_EN
        exp_ill = 1'b1;
`else
        exp_ill = 1'b0;
`endif
        rst_n = 1'b0;
        instr = 32'h2422_0005; instr_valid = 1'b1; enable = 1'b1; stall = 1'b0; flush = 1'b0;
        @(posedge clk_sys); @(posedge clk_sys); #1;
        check_eq("reset_bundle", 32'(bundle), 32'(BUB));
        check_eq("reset_halted", 32'(halted), 32'd0);
        check_eq("reset_illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;

        step(32'h2422_0005, 1, 1, 0, 0);
        check_eq("addiu", 32'(bundle), 32'(mk(4'b0001,1,2'b00,1,0,0,0,2'b00,0,0,0,0,0,0,1)));

        step(32'h9441_0004, 1, 1, 1, 0);
        check_eq("lhu_stalled", 32'(bundle), 32'(BUB));
        step(32'h9441_0004, 1, 1, 0, 0);
        check_eq("lhu", 32'(bundle), 32'(mk(4'b0000,1,2'b00,1,1,0,1,2'b01,1,0,0,0,0,0,1)));

        step(32'h0C00_0010, 1, 1, 0, 0);
        check_eq("jal", 32'(bundle), 32'(mk(4'b0000,0,2'b10,1,0,0,0,2'b00,0,0,0,1,0,1,1)));
        step(32'h1022_0003, 1, 1, 0, 1);
        check_eq("beq_flushed", 32'(bundle), 32'(BUB));

        tbl.push_back('{"add",   32'h0022_1820, mk(4'b0010,0,2'b01,1,0,0,0,2'b00,0,0,0,0,0,0,1)});
        tbl.push_back('{"jr",    32'h03E0_0008, mk(4'b0010,0,2'b01,0,0,0,0,2'b00,0,0,0,0,1,0,1)});
        tbl.push_back('{"jalr",  32'h0020_F809, mk(4'b0010,0,2'b01,1,0,0,0,2'b00,0,0,0,0,1,1,1)});
        tbl.push_back('{"lb",    32'h8022_0000, mk(4'b0000,1,2'b00,1,1,0,1,2'b00,0,0,0,0,0,0,1)});
        tbl.push_back('{"lh",    32'h8422_0000, mk(4'b0000,1,2'b00,1,1,0,1,2'b01,0,0,0,0,0,0,1)});
        tbl.push_back('{"lw",    32'h8C22_0004, mk(4'b0000,1,2'b00,1,1,0,1,2'b11,0,0,0,0,0,0,1)});
        tbl.push_back('{"lbu",   32'h9022_0000, mk(4'b0000,1,2'b00,1,1,0,1,2'b00,1,0,0,0,0,0,1)});
        tbl.push_back('{"lwu",   32'h9C22_0000, mk(4'b0000,1,2'b00,1,1,0,1,2'b11,1,0,0,0,0,0,1)});
        tbl.push_back('{"sb",    32'hA022_0000, mk(4'b0000,1,2'b00,0,0,1,0,2'b00,0,0,0,0,0,0,1)});
        tbl.push_back('{"sh",    32'hA422_0000, mk(4'b0000,1,2'b00,0,0,1,0,2'b01,0,0,0,0,0,0,1)});
        tbl.push_back('{"sw",    SW,            mk(4'b0000,1,2'b00,0,0,1,0,2'b11,0,0,0,0,0,0,1)});
        tbl.push_back('{"addi",  32'h2022_0005, mk(4'b0000,1,2'b00,1,0,0,0,2'b00,0,0,0,0,0,0,1)});
        tbl.push_back('{"slti",  32'h2822_0005, mk(4'b1100,1,2'b00,1,0,0,0,2'b00,0,0,0,0,0,0,1)});
        tbl.push_back('{"andi",  32'h3022_000F, mk(4'b0100,1,2'b00,1,0,0,0,2'b00,0,0,0,0,0,0,1)});
        tbl.push_back('{"lui",   32'h3C02_1234, mk(4'b1001,1,2'b00,1,0,0,0,2'b00,0,0,0,0,0,0,1)});
        tbl.push_back('{"bne",   32'h1422_0002, mk(4'b0111,0,2'b00,0,0,0,0,2'b00,0,0,1,0,0,0,1)});
        tbl.push_back('{"j",     32'h0800_0010, mk(4'b0000,0,2'b00,0,0,0,0,2'b00,0,0,0,1,0,0,1)});
        tbl.push_back('{"sltiu", 32'h2C22_0001, mk(4'b1101,1,2'b00,1,0,0,0,2'b00,0,0,0,0,0,0,1)});
        foreach (tbl[i]) begin
            step(tbl[i].ins, 1, 1, 0, 0);
            check_eq(tbl[i].tag, 32'(bundle), 32'(tbl[i].exp));
        end

        // SLTIU bundle must survive a disabled cycle even with flush asserted.
        step(32'h3422_0005, 1, 0, 0, 1);
        check_eq("enable_hold", 32'(bundle), 32'(mk(4'b1101,1,2'b00,1,0,0,0,2'b00,0,0,0,0,0,0,1)));
        step(32'h3422_0005, 0, 1, 0, 0);
        check_eq("invalid_bubble", 32'(bundle), 32'(BUB));

        step(32'h4000_0000, 1, 1, 0, 0);
        check_eq("illegal_bubble", 32'(bundle), 32'(BUB));
        check_eq("illegal_flag", 32'(illegal), 32'(exp_ill));
        step(32'h3822_0001, 1, 1, 0, 0);
        check_eq("xori", 32'(bundle), 32'(mk(4'b1000,1,2'b00,1,0,0,0,2'b00,0,0,0,0,0,0,1)));
        check_eq("illegal_sticky", 32'(illegal), 32'(exp_ill));

        step(HALT, 1, 1, 1, 0);
        check_eq("halt_stalled", 32'(bundle), 32'(BUB));
        step(HALT, 1, 1, 0, 1);
        check_eq("halt_flushed", 32'(bundle), 32'(BUB));
        step(32'h2022_0005, 1, 1, 0, 0);
        check_eq("run_after_blocked_halt", 32'(bundle), 32'(mk(4'b0000,1,2'b00,1,0,0,0,2'b00,0,0,0,0,0,0,1)));

        step(HALT, 1, 1, 0, 0);
        check_eq("halt_bubble", 32'(bundle), 32'(BUB));
        check_eq("halt_e0", 32'(halted), 32'd0);
        step(SW, 1, 1, 0, 0);
        check_eq("drain_e1", 32'(halted), 32'd0);
        check_eq("drain_bubble", 32'(bundle), 32'(BUB));
        step(SW, 1, 0, 0, 0);
        step(SW, 1, 0, 0, 0);
        check_eq("drain_hold", 32'(halted), 32'd0);
        step(SW, 1, 1, 0, 1);
        check_eq("drain_e2", 32'(halted), 32'd0);
        step(SW, 1, 1, 1, 0);
        check_eq("drain_e3", 32'(halted), 32'd1);
        check_eq("halted_bubble", 32'(bundle), 32'(BUB));
        step(SW, 1, 1, 0, 0);
        check_eq("halted_sw", 32'(bundle), 32'(BUB));
        check_eq("halted_stays", 32'(halted), 32'd1);

        rst_n = 1'b0;
        #2;
        check_eq("rst_from_halted", 32'(halted), 32'd0);
        rst_n = 1'b1;
        step(HALT, 1, 1, 0, 0);
        step(SW, 1, 1, 0, 0);
        rst_n = 1'b0;
        #2;
        check_eq("rst_drain_bundle", 32'(bundle), 32'(BUB));
        check_eq("rst_drain_halted", 32'(halted), 32'd0);
        check_eq("rst_drain_illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;
        step(32'h3422_0005, 1, 1, 0, 0);
        check_eq("ori_after_rst", 32'(bundle), 32'(mk(4'b0101,1,2'b00,1,0,0,0,2'b00,0,0,0,0,0,0,1)));
        step(SW, 1, 1, 0, 0);
        step(SW, 1, 1, 0, 0);
        step(SW, 1, 1, 0, 0);
        check_eq("no_halt_after_rst", 32'(halted), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
